codificador_interrupcao: RTL

Registered 8-to-3 priority encoder with request latching and a valid/ack handshake; the inverse of the 3-to-8 one-hot decoder used for register/device selection. It collects up to eight request lines into sticky pending bits, applies an enable mask, and offers the highest-priority pending index as a 3-bit code to the processor control unit. The code is held stable until the consumer acknowledges it, and the acknowledge clears the served request. It sits between peripheral request lines and the processor's interrupt/dispatch logic.

---
 rtl/codificador_interrupcao.sv | 116 +++++++++++
 1 files changed

// File: rtl/codificador_interrupcao.sv
`default_nettype none
// ============================================================================
// Module   : codificador_interrupcao
// Purpose  : Registered 8-to-3 priority encoder for interrupt/dispatch.
//            Request lines are latched into sticky pending bits, filtered by
//            a writable enable mask, and the highest pending, enabled index
//            is offered as a 3-bit code under a valid/ack handshake. An offer
//            stays frozen until it is acknowledged, and the acknowledge
//            clears the request that was served.
// Ports    : clock           - sole clock, rising edge
//            reset           - asynchronous, active-high, clears all state
//            entrada[7:0]    - request lines (set pending bits)
//            escreve_mascara - load mascara_in into the mask register
//            mascara_in[7:0] - new mask value (1 = request enabled)
//            ack             - consumer accepts current code (only if valido)
//            saida[2:0]      - offered request index (registered)
//            valido          - saida holds a live offer (registered)
//            pendente[7:0]   - pending register, unmasked
//            mascara[7:0]    - current mask register
// Revision : 1.0 - initial release
// ============================================================================
module codificador_interrupcao #(
    parameter logic [7:0] MASCARA_INICIAL = 8'hFF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] entrada,
    input  logic       escreve_mascara,
    input  logic [7:0] mascara_in,
    input  logic       ack,
    output logic [2:0] saida,
    output logic       valido,
    output logic [7:0] pendente,
    output logic [7:0] mascara
);

    typedef enum logic [0:0] {
        OCIOSO = 1'b0,
        OFERTA = 1'b1
    } estado_t;

    estado_t    estado;
    logic [7:0] limpa;
    logic [7:0] candidatos;
    logic [2:0] vencedor;
    logic       aceite;

    // An acknowledge only counts while an offer is live.
    assign aceite     = ack && valido;
    assign limpa      = aceite ? (8'd1 << saida) : 8'd0;
    assign candidatos = pendente & mascara;

    // Fixed priority: scanning upward lets the highest set index overwrite
    // any lower one, so bit 7 wins.
    always_comb begin
        vencedor = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (candidatos[i]) begin
                vencedor = 3'(i);
            end
        end
    end

    // Pending bits: clear is applied before set, so a request arriving on
    // the bit being acknowledged keeps that bit pending.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pendente <= 8'h00;
        end else begin
            pendente <= (pendente & ~limpa) | entrada;
        end
    end

    // Mask register; masked requests keep their pending bits.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mascara <= MASCARA_INICIAL;
        end else if (escreve_mascara) begin
            mascara <= mascara_in;
        end
    end

    // Offer FSM. Once an offer is made its code is frozen until ack, so a
    // newer higher-priority request or a mask change never retracts it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= OCIOSO;
            saida  <= 3'b000;
            valido <= 1'b0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (|candidatos) begin
                        saida  <= vencedor;
                        valido <= 1'b1;
                        estado <= OFERTA;
                    end else begin
                        valido <= 1'b0;
                    end
                end
                OFERTA: begin
                    if (ack) begin
                        valido <= 1'b0;
                        estado <= OCIOSO;
                    end
                end
                default: begin
                    valido <= 1'b0;
                    estado <= OCIOSO;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
